// File: rtl/screen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// screen_pkg: shared pixel levels and sprite state type for the screen pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
package screen_pkg;

  localparam int         PIX_W        = 8;
  localparam logic [7:0] BORDER_LVL   = 8'd255;
  localparam logic [7:0] BG_LVL       = 8'd50;
  localparam logic [7:0] SPR_BASE_LVL = 8'd128;
  localparam logic [7:0] SPR_LVL_STEP = 8'd16;

  typedef struct packed {
    logic [9:0] t;
    logic [9:0] l;
    logic       dir_y;
    logic       dir_x;
  } sprite_t;

  // Grey level of sprite idx; wraps naturally in 8 bits.
  function automatic logic [PIX_W-1:0] spr_level(input logic [2:0] idx);
    return SPR_BASE_LVL + (SPR_LVL_STEP * {5'd0, idx});
  endfunction

endpackage
`default_nettype wire

// File: rtl/screen_sprite_mover.sv
`default_nettype none
// ---------------------------------------------------------------------------
// screen_sprite_mover: one bouncing sprite, clamped to the legal playfield range
// Rev 1.0
// ---------------------------------------------------------------------------
module screen_sprite_mover
  import screen_pkg::*;
#(
  parameter int INDEX = 0,
  parameter int STEP  = 1,
  parameter int T_MAX = 327,
  parameter int L_MAX = 705
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    advance,
  output sprite_t spr
);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] T_LIM   = 11'(T_MAX);
  localparam logic [10:0] L_LIM   = 11'(L_MAX);
  localparam sprite_t     RST_VAL = '{
    t:     10'(1 + 16 * INDEX),
    l:     10'(1 + 32 * INDEX),
    dir_y: 1'b0,
    dir_x: 1'((INDEX % 2))
  };

  // Returns {dir, pos}; the direction flips on the same step that clamps.
  function automatic logic [10:0] axis_next(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    if (!dir) begin
      if (p + STEP_W >= lim) r = {1'b1, lim[9:0]};
      else                   r = {1'b0, 10'(p + STEP_W)};
    end else begin
      if (p <= 11'd1 + STEP_W) r = {1'b0, 10'd1};
      else                     r = {1'b1, 10'(p - STEP_W)};
    end
    return r;
  endfunction

  sprite_t     nxt;
  logic [10:0] ny;
  logic [10:0] nx;

  always_comb begin
    ny  = axis_next(spr.t, spr.dir_y, T_LIM);
    nx  = axis_next(spr.l, spr.dir_x, L_LIM);
    nxt = spr;
    if (advance) begin
      nxt.t     = ny[9:0];
      nxt.dir_y = ny[10];
      nxt.l     = nx[9:0];
      nxt.dir_x = nx[10];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) spr <= RST_VAL;
    else     spr <= nxt;
  end

endmodule
`default_nettype wire

// File: rtl/screen_sprite_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// screen_sprite_gen: N bouncing sprites composited over a bordered background
// Rev 1.0
// ---------------------------------------------------------------------------
module screen_sprite_gen #(
  parameter int MAX_COL    = 834,
  parameter int MAX_ROW    = 456,
  parameter int N_SPR      = 4,
  parameter int SPR_W      = 128,
  parameter int SPR_H      = 128,
  parameter int STEP       = 1,
  parameter int BORDER_LVL = 255,
  parameter int BG_LVL     = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [9:0]       pf_pix_row,
  input  logic [9:0]       pf_pix_col,
  output logic [7:0]       pix_val,
  output logic [N_SPR-1:0] spr_hit,
  output logic             collide
);
  import screen_pkg::*;

  localparam int T_MAX = MAX_ROW - 1 - SPR_H;
  localparam int L_MAX = MAX_COL - 1 - SPR_W;

  logic             vsync_q;
  logic             tick;
  logic             unused_hsync;
  sprite_t          spr [N_SPR];
  logic [N_SPR-1:0] cov;
  logic [10:0]      row_w;
  logic [10:0]      col_w;
  logic             border;
  logic [7:0]       level;
  logic [3:0]       n_cov;
  logic             overlap;
  logic             sticky;

  assign unused_hsync = hsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_q <= 1'b0;
    else     vsync_q <= vsync;
  end

  assign tick  = vsync & ~vsync_q;
  assign row_w = {1'b0, pf_pix_row};
  assign col_w = {1'b0, pf_pix_col};

  generate
    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
      screen_sprite_mover #(
        .INDEX (i),
        .STEP  (STEP),
        .T_MAX (T_MAX),
        .L_MAX (L_MAX)
      ) u_mover (
        .clk     (clk),
        .rst     (rst),
        .advance (tick & run),
        .spr     (spr[i])
      );

      // 11-bit compares so the far sprite edge never wraps.
      assign cov[i] = (row_w >= {1'b0, spr[i].t})
                    && (row_w <  ({1'b0, spr[i].t} + 11'(SPR_H)))
                    && (col_w >= {1'b0, spr[i].l})
                    && (col_w <  ({1'b0, spr[i].l} + 11'(SPR_W)));
    end
  endgenerate

  assign border = (pf_pix_row == 10'd0) || (pf_pix_row == 10'(MAX_ROW - 1))
               || (pf_pix_col == 10'd0) || (pf_pix_col == 10'(MAX_COL - 1));

  // Scan from the top index down so the lowest covering sprite wins.
  always_comb begin
    level = 8'(BG_LVL);
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (cov[i]) level = spr_level(3'(i));
    end
    if (border) level = 8'(BORDER_LVL);
  end

  always_comb begin
    n_cov = '0;
    for (int i = 0; i < N_SPR; i++) begin
      n_cov = n_cov + {3'd0, cov[i]};
    end
  end

  assign overlap = (n_cov >= 4'd2) && !border;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_val <= '0;
      spr_hit <= '0;
    end else begin
      pix_val <= level;
      spr_hit <= cov;
    end
  end

  // The pulse reports the frame just ended, including an overlap seen on the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky  <= 1'b0;
      collide <= 1'b0;
    end else if (tick) begin
      sticky  <= 1'b0;
      collide <= sticky | overlap;
    end else begin
      sticky  <= sticky | overlap;
      collide <= 1'b0;
    end
  end

endmodule
`default_nettype wire
